// File: rtl/seq_detect.sv
// Ascending-run detector: tracks a run 1..LEN (each value repeatable), flags and counts entries to LEN.
// Define SEQ_DETECT_SAT_EN to make the entry counter saturate instead of wrap.
module seq_detect #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned LEN   = 3,
    parameter int unsigned CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] num,
    input  logic             en,
    input  logic             clr,
    output logic             ans,
    output logic             hit,
    output logic [CW-1:0]    count
);

    localparam int unsigned LW = WIDTH + 1;

    localparam logic [WIDTH-1:0] LVL_IDLE = '0;
    localparam logic [WIDTH-1:0] LVL_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] LVL_TOP  = WIDTH'(LEN);
    localparam logic [CW-1:0]    CNT_MAX  = '1;

    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] lvl_nxt;
    logic             hit_nxt;
    logic [CW-1:0]    count_nxt;

    // Level register plus registered outputs; ans is the registered decode of the next level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl   <= LVL_IDLE;
            ans   <= 1'b0;
            hit   <= 1'b0;
            count <= '0;
        end else begin
            lvl   <= lvl_nxt;
            ans   <= (lvl_nxt == LVL_TOP);
            hit   <= hit_nxt;
            count <= count_nxt;
        end
    end

    // Next level chosen by first matching rule; a restart on 1 always wins.
    always_comb begin
        lvl_nxt   = lvl;
        hit_nxt   = 1'b0;
        count_nxt = count;
        if (clr) begin
            lvl_nxt   = LVL_IDLE;
            count_nxt = '0;
        end else if (en) begin
            if (num == LVL_ONE) begin
                lvl_nxt = LVL_ONE;
            end else if (lvl != LVL_IDLE && num == lvl) begin
                lvl_nxt = lvl;
            end else if (lvl != LVL_IDLE && lvl < LVL_TOP &&
                         {1'b0, num} == ({1'b0, lvl} + LW'(1))) begin
                lvl_nxt = num;
            end else begin
                lvl_nxt = LVL_IDLE;
            end

            hit_nxt = (lvl != LVL_TOP) && (lvl_nxt == LVL_TOP);
            if (hit_nxt) begin
`ifdef SEQ_DETECT_SAT_EN
                if (count != CNT_MAX) begin
                    count_nxt = count + CW'(1);
                end
`else
                count_nxt = count + CW'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_detect.sv
// Bench for seq_detect (WIDTH=2, LEN=3, CW=8): directed scenarios plus random traffic against a history-based model.
module tb_seq_detect;

    localparam int WIDTH = 2;
    localparam int LEN   = 3;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] num;
    logic             en;
    logic             clr;
    logic             ans;
    logic             hit;
    logic [CW-1:0]    count;

    int passed = 0;
    int total  = 0;

    // Model state: accepted symbols since last clear/reset, entry count, last hit.
    int hist[$];
    int mcount;
    bit mhit;
    int hits_seen;

    seq_detect #(.WIDTH(WIDTH), .LEN(LEN), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .num   (num),
        .en    (en),
        .clr   (clr),
        .ans   (ans),
        .hit   (hit),
        .count (count)
    );

    always #5 clk = ~clk;

    // Length k of the trailing run 1..k (repeats allowed) in the accepted history, else 0.
    function automatic int level_of();
        int i;
        int expect_v;
        int k;
        if (hist.size() == 0) return 0;
        i = hist.size() - 1;
        expect_v = hist[i];
        if (expect_v < 1 || expect_v > LEN) return 0;
        k = expect_v;
        forever begin
            while (i >= 0 && hist[i] == expect_v) i--;
            if (expect_v == 1) return k;
            expect_v--;
            if (i < 0 || hist[i] != expect_v) return 0;
        end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        hist.delete();
        mcount = 0;
        mhit   = 1'b0;
    endtask

    task automatic step(input logic e, input int n, input logic c, input string tag);
        int prev;
        int now;
        @(negedge clk);
        en  = e;
        num = WIDTH'(n);
        clr = c;
        @(posedge clk);
        prev = level_of();
        if (c) begin
            model_reset();
        end else if (e) begin
            hist.push_back(n);
            now  = level_of();
            mhit = (now == LEN) && (prev != LEN);
            if (mhit) begin
`ifdef SEQ_DETECT_SAT_EN
                if (mcount < (1 << CW) - 1) mcount++;
`else
                mcount = (mcount + 1) % (1 << CW);
`endif
            end
        end else begin
            mhit = 1'b0;
        end
        #1;
        if (hit) hits_seen++;
        chk({tag, "_ans"},   int'(ans),   int'(level_of() == LEN));
        chk({tag, "_hit"},   int'(hit),   int'(mhit));
        chk({tag, "_count"}, int'(count), mcount);
    endtask

    task automatic seq(input int vals[$], input string tag);
        foreach (vals[i]) step(1'b1, vals[i], 1'b0, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        num   = '0;
        clr   = 1'b0;
        model_reset();
        hits_seen = 0;
        #1;
        chk("rst_ans",   int'(ans),   0);
        chk("rst_hit",   int'(hit),   0);
        chk("rst_count", int'(count), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic entry and a held LEN without re-pulse.
        seq('{1, 2, 3}, "basic");
        chk("basic_hit_direct", int'(hit), 1);
        chk("basic_cnt_direct", int'(count), 1);
        step(1'b1, 3, 1'b0, "basic_hold");
        chk("hold_no_hit", int'(hit), 0);
        chk("hold_ans", int'(ans), 1);

        // Repeated values; ans high three cycles, one hit.
        do_reset();
        seq('{1, 1, 2, 2, 3, 3, 3, 0}, "repeat");
        chk("repeat_count", int'(count), 1);
        chk("repeat_ans_end", int'(ans), 0);

        // Skip, idle start, restart on 1, descend.
        do_reset();
        seq('{1, 3}, "skip");
        seq('{2, 3}, "noone");
        seq('{1, 2, 3, 1}, "restart");
        chk("restart_ans", int'(ans), 0);
        seq('{2, 3}, "restart_cont");
        chk("restart_cont_hit", int'(hit), 1);
        seq('{1, 2, 3, 2}, "descend");
        seq('{3}, "descend_after");
        chk("descend_after_hit", int'(hit), 0);

        // en low holds state; clr beats en.
        do_reset();
        seq('{1, 2}, "gate");
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, "gate_off");
        step(1'b1, 3, 1'b0, "gate_on");
        chk("gate_on_ans", int'(ans), 1);
        chk("gate_on_count", int'(count), 1);
        step(1'b1, 3, 1'b1, "clr");
        chk("clr_count", int'(count), 0);
        chk("clr_hit", int'(hit), 0);
        chk("clr_ans", int'(ans), 0);

        // 256 entries: wrap or saturate.
        do_reset();
        hits_seen = 0;
        for (int i = 0; i < 256; i++) seq('{1, 2, 3}, "wrap");
        chk("wrap_hits", hits_seen, 256);
`ifdef SEQ_DETECT_SAT_EN
        chk("wrap_final", int'(count), 255);
`else
        chk("wrap_final", int'(count), 0);
`endif

        // Asynchronous reset in the hit cycle with count=5.
        do_reset();
        for (int i = 0; i < 5; i++) seq('{1, 2, 3}, "pre_arst");
        chk("pre_arst_count", int'(count), 5);
        chk("pre_arst_hit", int'(hit), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ans",   int'(ans),   0);
        chk("arst_hit",   int'(hit),   0);
        chk("arst_count", int'(count), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seq('{2, 3}, "post_arst");
        chk("post_arst_ans", int'(ans), 0);
        seq('{1, 2, 3}, "post_arst_entry");

        // Random traffic, biased toward ascending runs.
        for (int i = 0; i < 600; i++) begin
            int r;
            int n;
            r = int'($urandom_range(0, 99));
            if (r < 60) n = (level_of() % LEN) + 1;
            else n = int'($urandom_range(0, 3));
            step(($urandom_range(0, 9) != 0), n, ($urandom_range(0, 49) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_detect.md
SEQ_DETECT -- requirements
Module: seq_detect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the symbol width in bits (legal range 1..8).
REQ-002 The block SHALL have parameter LEN, default 3, giving the target run length (legal range 1..2^WIDTH-1).
REQ-003 The block SHALL have parameter CW, default 8, giving the match-counter width in bits (legal range 1..32).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port num, input, WIDTH bits: the symbol sampled each enabled cycle.
REQ-008 The block SHALL have port en, input, 1 bit: symbol-valid; when low, num is ignored and state holds.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear of level and counter.
REQ-010 The block SHALL have port ans, output, 1 bit: high while the detector is at level LEN.
REQ-011 The block SHALL have port hit, output, 1 bit: one-cycle pulse on each entry into level LEN.
REQ-012 The block SHALL have port count, output, CW bits: number of entries into level LEN.

Function
REQ-013 The block SHALL keep a registered level L in 0..LEN, where L=k means the last accepted symbols form the ascending run 1..k, each value repeated one or more times.
REQ-014 On a rising edge with en=1 and clr=0, the next level SHALL be chosen by the first matching rule: num==1 -> 1; L>=1 and num==L -> L; 1<=L<LEN and num==L+1 -> L+1; otherwise 0.
REQ-015 At L=LEN, num==LEN SHALL hold the level, num==1 SHALL go to level 1, and any other value SHALL go to 0 (no advance beyond LEN).
REQ-016 A skipped value (e.g. 1 then 3) or a descending value other than 1 SHALL go to level 0.
REQ-017 With en=0 and clr=0, L, count and ans SHALL hold, and hit SHALL be 0.
REQ-018 clr=1 SHALL set L=0, count=0 and hit=0 on the next edge, with priority over en.
REQ-019 ans SHALL equal (L==LEN), decoded from the register with no combinational path from num; it therefore rises one cycle after the edge that samples the final symbol.
REQ-020 hit SHALL be a register set to 1 on an edge where en=1, clr=0, L!=LEN and the next level is LEN, and cleared otherwise.
REQ-021 hit SHALL be high exactly in the first cycle that ans is high for each entry; repeats of LEN SHALL NOT re-pulse hit.
REQ-022 count SHALL increment by 1 on every edge that sets hit.
REQ-023 When LEN=1, any num==1 from L!=1 SHALL be an entry, and num==1 at L=1 SHALL hold the level without a new hit.

Reset
REQ-024 reset=1 SHALL force L=0, ans=0, hit=0 and count=0 immediately, with no clock edge required.
REQ-025 reset SHALL override clr and en.
REQ-026 Reset asserted mid-sequence or while ans=1 SHALL discard the partial run; detection SHALL restart from level 0 on the first edge after release.
REQ-027 The block SHALL NOT rely on initial values for correct behaviour.

Configuration
REQ-028 Macro SEQ_DETECT_SAT_EN, when defined, SHALL make count saturate at 2^CW-1, so further entries still pulse hit but leave count unchanged.
REQ-029 When SEQ_DETECT_SAT_EN is undefined, count SHALL wrap from 2^CW-1 to 0 on the next entry.

Verification (WIDTH=2, LEN=3, CW=8)
REQ-030 The bench SHALL cover: reset, en=1, num=1,2,3 -> ans=1 and hit=1 in the cycle after the 3 is sampled, count=1; the next cycle num=3 -> ans=1, hit=0.
REQ-031 The bench SHALL cover: num=1,1,2,2,3,3,3,0 -> ans high 3 cycles, then 0; hit exactly once; count=1.
REQ-032 The bench SHALL cover: num=1,3 -> L=0; num=2,3 from idle -> no ans; num=1,2,3,1 -> L=1, ans=0; num=1,2,3,2 -> L=0.
REQ-033 The bench SHALL cover: num=1,2, then en=0 with num=0 for 4 cycles, then en=1 num=3 -> ans=1 and count increments; clr asserted with en=1 num=3 -> L=0, count=0, hit=0.
REQ-034 The bench SHALL cover: 256 matches from count=0 -> count=255 with SEQ_DETECT_SAT_EN defined, count=0 without it; hit pulses all 256 times in both builds.
REQ-035 The bench SHALL cover: reset asserted between edges while ans=1 and count=5 -> ans, hit and count read 0 before the next edge.
